// File: rtl/lz77_decoder_stream.sv
// lz77_decoder_stream
// Streaming LZ77 decoder. Each accepted (pos, len, char) codeword expands
// into len characters copied from the sliding search buffer followed by the
// literal char. Emitting the terminator character latches finish and stops
// the decoder until reset.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   code_valid  codeword present
//   code_ready  decoder can accept a codeword (registered)
//   code_pos    match distance minus 1 (0 = most recent char)
//   code_len    match length
//   chardata    literal appended after the match
//   char_valid  one-cycle qualifier for char_nxt
//   char_nxt    decoded character (holds when char_valid=0)
//   encode      mode flag, constant 0 (decode-only)
//   finish      terminator has been emitted (held until reset)
//   err         sticky position error
//
// Optional feature macro: LZ77_POS_CHECK_EN
//   defined   -> err flags codewords whose match reaches past the chars
//                decoded so far or past the buffer depth
//   undefined -> err is tied 0 and the fill counter is not built
module lz77_decoder_stream #(
  parameter int CHAR_W       = 8,
  parameter int SEARCH_DEPTH = 9,
  parameter int POS_W        = 4,
  parameter int LEN_W        = 3,
  parameter int TERM_CHAR    = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [POS_W-1:0]  code_pos,
  input  logic [LEN_W-1:0]  code_len,
  input  logic [CHAR_W-1:0] chardata,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_nxt,
  output logic              encode,
  output logic              finish,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;

  state_t             state_reg;
  logic [POS_W-1:0]   pos_reg;
  logic [LEN_W-1:0]   remaining_reg;
  logic [CHAR_W-1:0]  char_reg;
  logic               code_ready_reg;
  logic               char_valid_reg;
  logic [CHAR_W-1:0]  char_nxt_reg;
  logic               finish_reg;

  // buf_mem[0] is the newest character
  logic [CHAR_W-1:0]  buf_mem [SEARCH_DEPTH];

  logic               accept;
  logic               emit;
  logic [CHAR_W-1:0]  rd_char;
  logic [CHAR_W-1:0]  emit_char;

  assign accept = (state_reg == IDLE) && code_ready_reg && code_valid;
  assign emit   = (state_reg == COPY) || (state_reg == LIT);

  // Positions beyond the buffer depth match no entry and read as 0.
  always_comb begin
    rd_char = '0;
    for (int i = 0; i < SEARCH_DEPTH; i++) begin
      if (pos_reg == POS_W'(i)) rd_char = buf_mem[i];
    end
  end

  assign emit_char = (state_reg == COPY) ? rd_char : char_reg;

  // Shifting every emitted char (copies included) is what makes
  // overlapping matches (pos < len) reproduce run-length patterns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SEARCH_DEPTH; i++) buf_mem[i] <= '0;
    end else if (emit) begin
      buf_mem[0] <= emit_char;
      for (int i = 1; i < SEARCH_DEPTH; i++) buf_mem[i] <= buf_mem[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pos_reg        <= '0;
      remaining_reg  <= '0;
      char_reg       <= '0;
      code_ready_reg <= 1'b0;
      char_valid_reg <= 1'b0;
      char_nxt_reg   <= '0;
      finish_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          char_valid_reg <= 1'b0;
          if (!code_ready_reg) begin
            // first cycle out of reset: raise ready
            code_ready_reg <= 1'b1;
          end else if (code_valid) begin
            pos_reg        <= code_pos;
            char_reg       <= chardata;
            remaining_reg  <= code_len;
            code_ready_reg <= 1'b0;
            state_reg      <= (code_len == '0) ? LIT : COPY;
          end
        end
        COPY: begin
          char_valid_reg <= 1'b1;
          char_nxt_reg   <= rd_char;
          remaining_reg  <= remaining_reg - LEN_W'(1);
          if (remaining_reg == LEN_W'(1)) state_reg <= LIT;
        end
        LIT: begin
          char_valid_reg <= 1'b1;
          char_nxt_reg   <= char_reg;
          if (char_reg == CHAR_W'(TERM_CHAR)) begin
            finish_reg <= 1'b1;
            state_reg  <= DONE;
          end else begin
            code_ready_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          // DONE: hold everything until reset
          char_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef LZ77_POS_CHECK_EN
  localparam int FILL_W = $clog2(SEARCH_DEPTH + 1);

  logic [FILL_W-1:0] fill_reg;
  logic              err_reg;
  logic              pos_bad;

  assign pos_bad = (code_len != '0) &&
                   ((int'(code_pos) >= int'(fill_reg)) || (int'(code_pos) >= SEARCH_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (emit && (int'(fill_reg) < SEARCH_DEPTH)) fill_reg <= fill_reg + FILL_W'(1);
      if (accept && pos_bad) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign code_ready = code_ready_reg;
  assign char_valid = char_valid_reg;
  assign char_nxt   = char_nxt_reg;
  assign finish     = finish_reg;
  assign encode     = 1'b0;

endmodule

// File: tb/tb_lz77_decoder_stream.sv
// Testbench for lz77_decoder_stream: directed and randomized codewords,
// checked against a queue-based model of the LZ77 expansion rules.
module tb_lz77_decoder_stream;

  localparam int CW   = 8;
  localparam int SD   = 9;
  localparam int PW   = 4;
  localparam int LW   = 3;
  localparam logic [7:0] TERM = 8'h24;

  logic          clk;
  logic          reset;
  logic          code_valid;
  logic          code_ready;
  logic [PW-1:0] code_pos;
  logic [LW-1:0] code_len;
  logic [CW-1:0] chardata;
  logic          char_valid;
  logic [CW-1:0] char_nxt;
  logic          encode;
  logic          finish;
  logic          err;

  lz77_decoder_stream #(
    .CHAR_W(CW), .SEARCH_DEPTH(SD), .POS_W(PW), .LEN_W(LW), .TERM_CHAR(36)
  ) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
    .code_pos(code_pos), .code_len(code_len), .chardata(chardata),
    .char_valid(char_valid), .char_nxt(char_nxt), .encode(encode),
    .finish(finish), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {finish, char} captured for every valid output char
  logic [8:0] got_q[$];
  always @(negedge clk) if (char_valid === 1'b1) got_q.push_back({finish, char_nxt});

  // reference model: history queue, newest at the front
  logic [7:0] hist_q[$];
  logic [8:0] exp_q[$];
  int         total_m;
  logic       err_m;

  int chk_total = 0;
  int chk_pass  = 0;
  int chk_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_total++;
    assert (obs === exp) chk_pass++;
    else begin
      chk_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist_q.delete();
    exp_q.delete();
    got_q.delete();
    total_m = 0;
    err_m   = 1'b0;
  endtask

  task automatic model_emit(input logic [7:0] c, input logic fin);
    exp_q.push_back({fin, c});
    hist_q.push_front(c);
    if (hist_q.size() > SD) void'(hist_q.pop_back());
    total_m++;
  endtask

  task automatic model_code(input int pos, input int len, input logic [7:0] ch);
    logic [7:0] c;
`ifdef LZ77_POS_CHECK_EN
    if (len != 0 && (pos >= ((total_m < SD) ? total_m : SD) || pos >= SD)) err_m = 1'b1;
`endif
    for (int k = 0; k < len; k++) begin
      c = (pos < hist_q.size()) ? hist_q[pos] : 8'h00;
      model_emit(c, 1'b0);
    end
    model_emit(ch, ch == TERM);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    code_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  // with code_valid still asserted.
  task automatic send(input int pos, input int len, input logic [7:0] ch, output int acc_cyc);
    int n;
    code_pos   = PW'(pos);
    code_len   = LW'(len);
    chardata   = ch;
    code_valid = 1'b1;
    n = 0;
    while (code_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (n >= 60) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("ready_low_after_accept", code_ready, 1'b0);
      model_code(pos, len, ch);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    int m;
    code_valid = 1'b0;
    n = 0;
    while (!(code_ready === 1'b1 || finish === 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_char%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_err"}, err, err_m);
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] rand_char();
    return 8'($urandom_range(97, 122));
  endfunction

  initial begin
    int acc;
    int prev_acc;
    int prev_len;
    int len;
    logic [7:0] first_lit;

    reset      = 1'b0;
    code_valid = 1'b0;
    code_pos   = '0;
    code_len   = '0;
    chardata   = '0;
    model_reset();
    #1;
    check("rst_char_valid", char_valid, 1'b0);
    check("rst_char_nxt", char_nxt, 8'h00);
    check("rst_finish", finish, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_encode", encode, 1'b0);
    check("rst_code_ready", code_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset in the middle of a copy
    send(0, 3, 8'h61, acc);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_char_valid", char_valid, 1'b0);
    check("midrst_char_nxt", char_nxt, 8'h00);
    check("midrst_finish", finish, 1'b0);
    check("midrst_code_ready", code_ready, 1'b0);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    code_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("midrst_ready_after", code_ready, 1'b1);
    send(0, 0, 8'h78, acc);
    drain("midrst_lit_x");

    // literals, terminator, then DONE ignores input
    do_reset();
    send(0, 0, 8'h61, acc); drain("lit_a");
    send(0, 0, 8'h62, acc); drain("lit_b");
    send(0, 0, TERM, acc);  drain("lit_term");
    check("done_finish", finish, 1'b1);
    check("done_ready", code_ready, 1'b0);
    code_valid = 1'b1;
    code_len   = LW'(2);
    chardata   = 8'h71;
    repeat (5) @(negedge clk);
    #1;
    code_valid = 1'b0;
    check("done_no_chars", got_q.size(), 0);
    check("done_finish_held", finish, 1'b1);
    check("done_char_held", char_nxt, TERM);

    // overlapping copy
    do_reset();
    send(0, 0, 8'h61, acc); drain("ovl_a");
    send(0, 0, 8'h62, acc); drain("ovl_b");
    send(1, 5, 8'h63, acc);
    drain("ovl_copy");

    // oldest buffer entry and out-of-range position
    do_reset();
    first_lit = rand_char();
    send(0, 0, first_lit, acc);
    for (int i = 1; i < SD; i++) send(0, 0, rand_char(), acc);
    drain("depth_fill");
    send(SD + 3, 2, rand_char(), acc);
    drain("depth_oor");
    send(SD - 1, 1, TERM, acc);
    drain("depth_oldest");
    check("depth_finish", finish, 1'b1);

    // position check scenario
    do_reset();
    send(0, 0, 8'h70, acc);
    send(0, 0, 8'h71, acc);
    send(5, 2, 8'h7a, acc);
    drain("poschk");
`ifdef LZ77_POS_CHECK_EN
    check("poschk_err_held", err, 1'b1);
`else
    check("poschk_err_held", err, 1'b0);
`endif

    // back-to-back with code_valid held high
    do_reset();
    prev_acc = 0;
    prev_len = -1;
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(0, 7);
      send($urandom_range(0, SD - 1), len, rand_char(), acc);
      if (prev_len >= 0) check($sformatf("b2b_gap%0d", i), acc - prev_acc, prev_len + 2);
      prev_acc = acc;
      prev_len = len;
    end
    drain("b2b");

    // randomized codewords
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 15), $urandom_range(0, 7), rand_char(), acc);
      drain($sformatf("rnd%0d", i));
    end
    send($urandom_range(0, SD - 1), $urandom_range(0, 7), TERM, acc);
    drain("rnd_term");
    check("rnd_finish", finish, 1'b1);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
